// File: rtl/cam_udp_pkt_sched.sv
// Packet scheduler from the camera FIFO to eth_udp: sizes and starts UDP packets,
// prepends an optional {frame, seq} header word and flushes partial packets on a quiet timeout.
module cam_udp_pkt_sched #(
  parameter int DATA_W    = 32,
  parameter int PKT_BYTES = 1280,
  parameter int USEDW_W   = 10,
  parameter int HDR_EN    = 1,
  parameter int BYTE_SWAP = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_empty,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  output logic               send_en,
  output logic [15:0]        send_data_num,
  input  logic               read_data_req,
  output logic [DATA_W-1:0]  send_data,
  input  logic               send_end,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        pkt_seq,
  output logic               busy,
  output logic               underrun
);
  localparam int BPW   = DATA_W / 8;
  localparam int WPP   = PKT_BYTES / BPW;
  localparam int H     = (HDR_EN != 0) ? 1 : 0;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, HDR, PAY, WAIT_END} state_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_HDR, SEL_FIFO, SEL_ZERO} sel_t;

  state_t             state_q, state_d;
  sel_t               sel_q, sel_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [15:0]        left_q, left_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        frame_q, frame_d;
  logic [15:0]        seq_q, seq_d;
  logic               pend_q, pend_d;
  logic               ur_q, ur_d;
  logic [DATA_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0]  pay_word;
  logic [15:0]        n_sel;
  logic               usedw_nz, usedw_full, timeout_hit, pay_req;

  assign usedw_nz    = |fifo_usedw;
  assign usedw_full  = (32'(fifo_usedw) >= 32'(WPP));
  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));
  assign n_sel       = usedw_full ? 16'(WPP) : 16'(fifo_usedw);

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (genvar gi = 0; gi < BPW; gi++) begin : g_byte
        assign pay_word[8*gi +: 8] = fifo_q[DATA_W-8-8*gi +: 8];
      end
    end else begin : g_pass
      assign pay_word = fifo_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (usedw_full || (usedw_nz && timeout_hit)) state_d = START;
      START:    state_d = (H == 1) ? HDR : PAY;
      HDR:      if (read_data_req) state_d = PAY;
      PAY:      if (read_data_req && left_q == 16'd1) state_d = WAIT_END;
      WAIT_END: if (send_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    send_en    = (state_q == START);
    busy       = (state_q != IDLE);
    pay_req    = (state_q == PAY) && read_data_req && (left_q != 16'd0);
    fifo_rdreq = pay_req && !fifo_empty;
  end

  // Word select is registered so it lines up with the FIFO's one-cycle read latency.
  always_comb begin
    case (sel_q)
      SEL_HDR:  send_data = DATA_W'({frame_q, seq_q});
      SEL_FIFO: send_data = pay_word;
      SEL_ZERO: send_data = '0;
      default:  send_data = last_q;
    endcase
  end

  always_comb begin
    timer_d = (state_q == IDLE && state_d == IDLE && usedw_nz && !frame_start)
              ? timer_q + TMR_W'(1) : '0;
    left_d  = left_q;
    num_d   = num_q;
    frame_d = frame_q;
    seq_d   = seq_q;
    pend_d  = pend_q;
    ur_d    = ur_q;
    sel_d   = SEL_HOLD;
    last_d  = send_data;

    if (state_q == IDLE && state_d == START) begin
      left_d = n_sel;
      num_d  = 16'((32'(n_sel) + H) * BPW);
    end

    if (state_q == HDR && read_data_req) sel_d = SEL_HDR;

    // An underrun read still consumes a word slot so the announced length stays exact.
    if (pay_req) begin
      left_d = left_q - 16'd1;
      if (fifo_empty) begin
        sel_d = SEL_ZERO;
        ur_d  = 1'b1;
      end else begin
        sel_d = SEL_FIFO;
      end
    end

    if (state_q == IDLE) begin
      if (frame_start) begin
        frame_d = frame_q + 16'd1;
        seq_d   = 16'd0;
      end
    end else if (state_q == WAIT_END && send_end) begin
      if (pend_q || frame_start) begin
        frame_d = frame_q + 16'd1;
        seq_d   = 16'd0;
      end else begin
        seq_d   = seq_q + 16'd1;
      end
      pend_d = 1'b0;
    end else if (frame_start) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= SEL_HOLD;
      timer_q <= '0;
      left_q  <= '0;
      num_q   <= '0;
      frame_q <= '0;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      ur_q    <= 1'b0;
      last_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      num_q   <= num_d;
      frame_q <= frame_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      ur_q    <= ur_d;
      last_q  <= last_d;
    end
  end

  assign send_data_num = num_q;
  assign frame_cnt     = frame_q;
  assign pkt_seq       = seq_q;
  assign underrun      = ur_q;

endmodule

// File: tb/tb_cam_udp_pkt_sched.sv
// Bench for cam_udp_pkt_sched: default instance plus a no-header, no-swap instance,
// driven through a shared packet task with a simple registered FIFO model.
module tb_cam_udp_pkt_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, frame_start, empty, req, send_end, sel;
  logic [9:0]  usedw;
  logic [31:0] q = 32'd0;
  int          rd_total = 0;
  int          checks = 0;
  int          failures = 0;

  logic        rdreq0, send_en0, busy0, ur0, rdreq1, send_en1, busy1, ur1;
  logic [15:0] num0, fc0, ps0, num1, fc1, ps1;
  logic [31:0] sd0, sd1;
  logic [9:0]  usedw0, usedw1;
  logic        fs0, fs1, req0, req1, end0, end1;

  assign usedw0 = sel ? 10'd0 : usedw;
  assign usedw1 = sel ? usedw : 10'd0;
  assign fs0    = sel ? 1'b0 : frame_start;
  assign fs1    = sel ? frame_start : 1'b0;
  assign req0   = sel ? 1'b0 : req;
  assign req1   = sel ? req : 1'b0;
  assign end0   = sel ? 1'b0 : send_end;
  assign end1   = sel ? send_end : 1'b0;

  logic        rdreq_m, send_en_m, busy_m, ur_m;
  logic [15:0] num_m, fc_m, ps_m;
  logic [31:0] sd_m;
  assign rdreq_m   = sel ? rdreq1 : rdreq0;
  assign send_en_m = sel ? send_en1 : send_en0;
  assign busy_m    = sel ? busy1 : busy0;
  assign ur_m      = sel ? ur1 : ur0;
  assign num_m     = sel ? num1 : num0;
  assign fc_m      = sel ? fc1 : fc0;
  assign ps_m      = sel ? ps1 : ps0;
  assign sd_m      = sel ? sd1 : sd0;

  cam_udp_pkt_sched dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs0), .fifo_usedw(usedw0), .fifo_empty(empty),
    .fifo_q(q), .fifo_rdreq(rdreq0), .send_en(send_en0), .send_data_num(num0),
    .read_data_req(req0), .send_data(sd0), .send_end(end0), .frame_cnt(fc0),
    .pkt_seq(ps0), .busy(busy0), .underrun(ur0)
  );

  cam_udp_pkt_sched #(.HDR_EN(0), .BYTE_SWAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs1), .fifo_usedw(usedw1), .fifo_empty(empty),
    .fifo_q(q), .fifo_rdreq(rdreq1), .send_en(send_en1), .send_data_num(num1),
    .read_data_req(req1), .send_data(sd1), .send_end(end1), .frame_cnt(fc1),
    .pkt_seq(ps1), .busy(busy1), .underrun(ur1)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'h11223344 + 32'h01010101 * 32'(i);
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Normal-mode FIFO: data for a read appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rdreq_m) begin
      q        <= pat(rd_total);
      rd_total <= rd_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_pkt(input bit d, input int uw, input int empty_at, input int nfs,
                         input int lat, input int num, input int reads, input logic [31:0] hdr_w,
                         input int exp_frame, input int exp_seq, input bit exp_ur);
    int cyc, rd0, j, werr, nw, h, kind_prev;
    logic [31:0] exp_prev, bad_act, bad_exp;
    sel = d;
    h   = d ? 0 : 1;
    nw  = num / 4;
    @(negedge clk);
    usedw = 10'(uw);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!send_en_m && cyc < lat + 50);
    usedw = 10'd0;
    check("start_latency", cyc, lat);
    check("send_en", 32'(send_en_m), 32'd1);
    check("send_data_num", 32'(num_m), num);
    @(negedge clk);
    check("send_en_one_cycle", 32'(send_en_m), 32'd0);
    rd0 = rd_total; j = 0; werr = 0; kind_prev = 0;
    exp_prev = 32'd0; bad_act = 32'd0; bad_exp = 32'd0;
    for (int k = 0; k <= nw; k++) begin
      if (k > 0) begin
        if (kind_prev == 0) check("header_word", sd_m, exp_prev);
        else if (kind_prev == 1) check("underrun_word", sd_m, 32'd0);
        else if (sd_m !== exp_prev) begin
          if (werr == 0) begin bad_act = sd_m; bad_exp = exp_prev; end
          werr++;
        end
      end
      frame_start = (nfs >= 1 && k == 5) || (nfs >= 2 && k == 7);
      if (k < nw) begin
        req = 1'b1;
        if (k < h) begin
          kind_prev = 0; exp_prev = hdr_w; empty = 1'b0;
        end else if (k - h == empty_at) begin
          kind_prev = 1; exp_prev = 32'd0; empty = 1'b1;
        end else begin
          kind_prev = 2;
          exp_prev  = d ? pat(rd0 + j) : swap32(pat(rd0 + j));
          j++;
          empty = 1'b0;
        end
      end else begin
        req = 1'b0; empty = 1'b0;
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
    check("payload_word_errors", werr, 32'd0);
    if (werr != 0) $display("  first bad payload word actual=0x%0h expected=0x%0h", bad_act, bad_exp);
    req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    check("busy_wait_end", 32'(busy_m), 32'd1);
    check("send_data_hold", sd_m, exp_prev);
    check("fifo_reads", rd_total - rd0, reads);
    send_end = 1'b1;
    @(negedge clk);
    send_end = 1'b0;
    check("busy_idle", 32'(busy_m), 32'd0);
    check("frame_cnt", 32'(fc_m), exp_frame);
    check("pkt_seq", 32'(ps_m), exp_seq);
    check("underrun", 32'(ur_m), 32'(exp_ur));
    check("send_data_num_held", 32'(num_m), num);
    $display("pkt dut=%0d usedw=%0d bytes=%0d reads=%0d frame=%0d seq=%0d", d, uw, num_m,
             rd_total - rd0, fc_m, ps_m);
  endtask

  typedef struct {
    int          uw;
    int          empty_at;
    int          nfs;
    int          lat;
    int          num;
    int          reads;
    logic [31:0] hdr;
    int          frame;
    int          seq;
    bit          ur;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc;
    tbl[0] = '{320,  -100, 0, 1,    1284, 320, 32'h0000_0000, 0, 1, 1'b0};
    tbl[1] = '{400,  -100, 0, 1,    1284, 320, 32'h0000_0001, 0, 2, 1'b0};
    tbl[2] = '{320,  -100, 1, 1,    1284, 320, 32'h0000_0002, 1, 0, 1'b0};
    tbl[3] = '{320,  -100, 2, 1,    1284, 320, 32'h0001_0000, 2, 0, 1'b0};
    tbl[4] = '{17,   -100, 0, 4096, 72,   17,  32'h0002_0000, 2, 1, 1'b0};
    tbl[5] = '{320,  100,  0, 1,    1284, 319, 32'h0002_0001, 2, 2, 1'b1};
    tbl[6] = '{320,  -100, 0, 1,    1284, 320, 32'h0002_0002, 2, 3, 1'b1};

    rst_n = 1'b1; frame_start = 1'b0; empty = 1'b0; req = 1'b0; send_end = 1'b0;
    sel = 1'b0; usedw = 10'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send_en", 32'(send_en0), 32'd0);
    check("rst_fifo_rdreq", 32'(rdreq0), 32'd0);
    check("rst_send_data_num", 32'(num0), 32'd0);
    check("rst_send_data", sd0, 32'd0);
    check("rst_frame_cnt", 32'(fc0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_underrun", 32'(ur0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_pkt(1'b0, tbl[i].uw, tbl[i].empty_at, tbl[i].nfs, tbl[i].lat, tbl[i].num,
              tbl[i].reads, tbl[i].hdr, tbl[i].frame, tbl[i].seq, tbl[i].ur);
    end

    // frame_start while idle takes effect immediately
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("idle_fs_frame_cnt", 32'(fc0), 32'd3);
    check("idle_fs_pkt_seq", 32'(ps0), 32'd0);
    $display("idle frame_start frame=%0d seq=%0d", fc0, ps0);

    // asynchronous reset in the middle of the payload
    sel = 1'b0;
    @(negedge clk);
    usedw = 10'd320;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!send_en_m && cyc < 60);
    usedw = 10'd0;
    check("midrst_start", 32'(send_en_m), 32'd1);
    @(negedge clk);
    req = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_pre_rdreq", 32'(rdreq0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_fifo_rdreq", 32'(rdreq0), 32'd0);
    check("midrst_send_data", sd0, 32'd0);
    check("midrst_send_data_num", 32'(num0), 32'd0);
    check("midrst_frame_cnt", 32'(fc0), 32'd0);
    check("midrst_underrun", 32'(ur0), 32'd0);
    $display("reset mid-payload busy=%0d rdreq=%0d", busy0, rdreq0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(1'b0, 320, -100, 0, 1, 1284, 320, 32'h0000_0000, 0, 1, 1'b0);

    run_pkt(1'b1, 320, -100, 0, 1, 1280, 320, 32'h0000_0000, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_udp_pkt_sched.md
Name: cam_udp_pkt_sched

Overview:
Packet scheduler between the camera FIFO read port and eth_udp, clocked in the MII transmit domain.
- Decides when to start a UDP packet and how many bytes it carries.
- Optionally prepends a per-packet header word {frame, sequence}.
- Applies a selectable byte order to payload words.
- Flushes a partial packet after a quiet timeout, so the tail of each frame is still sent.

Parameters:
DATA_W, 32, FIFO/UDP word width in bits; multiple of 8, ≥32.
PKT_BYTES, 1280, payload bytes of a full packet; multiple of DATA_W/8. WPP = PKT_BYTES/(DATA_W/8) words (320 at default).
USEDW_W, 10, width of the fifo_usedw input.
HDR_EN, 1, 1 = prepend one header word per packet.
BYTE_SWAP, 1, 1 = reverse byte order of each payload word; 0 = pass through unchanged.
TIMEOUT, 4096, idle cycles with a nonzero sub-threshold FIFO level before a partial flush.

Ports:
clk  in  1  MII tx clock (25 MHz).
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  one-cycle pulse per new frame, already synchronised to clk.
fifo_usedw  in  USEDW_W  FIFO read-side fill level in words.
fifo_empty  in  1  FIFO empty flag.
fifo_q  in  DATA_W  FIFO data; normal mode, valid the cycle after fifo_rdreq.
fifo_rdreq  out  DATA_W/DATA_W=1  FIFO read strobe.
send_en  out  1  one-cycle packet start pulse to eth_udp.
send_data_num  out  16  packet byte count.
read_data_req  in  1  eth_udp word request; data is expected on the following cycle.
send_data  out  DATA_W  word to eth_udp.
send_end  in  1  eth_udp packet-done pulse.
frame_cnt  out  16  frame counter.
pkt_seq  out  16  packet index within the current frame.
busy  out  1  high in any state other than IDLE.
underrun  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state = IDLE; timer, counters and flags 0.

Constants:
- BPW = DATA_W/8.
- H = HDR_EN ? 1 : 0.

FSM states: IDLE, START, HDR, PAY, WAIT_END.

IDLE:
- If fifo_usedw ≥ WPP: latch n = WPP and go to START.
- Else if fifo_usedw ≠ 0 and timer == TIMEOUT−1: latch n = fifo_usedw and go to START (partial flush).
- Timer increments while fifo_usedw ≠ 0. It clears when fifo_usedw == 0, on frame_start, or on leaving IDLE.

START:
- send_en = 1 for exactly one cycle.
- send_data_num = (n + H) × BPW, registered. It is held constant until the next START.
- Default values: full packet with header = 1284 bytes; full packet without header = 1280 bytes.
- Next state: HDR if HDR_EN = 1, else PAY.

HDR:
- The first read_data_req is the header read. fifo_rdreq stays 0.
- On the next cycle, send_data = {frame_cnt, pkt_seq} zero-extended to DATA_W. A registered select flag chooses this.
- Then go to PAY.

PAY:
- fifo_rdreq = read_data_req, while the words-left counter (loaded with n) is > 0. The counter decrements on each read.
- send_data = the byte-ordered fifo_q, valid one cycle after the request.
- When the counter reaches 0 after the last read, go to WAIT_END.
- If read_data_req arrives while fifo_empty = 1:
  - fifo_rdreq is suppressed and send_data = 0 on the next cycle.
  - underrun is set, and the counter still decrements, so the packet length stays correct.

WAIT_END:
- On send_end: pkt_seq increments and the FSM returns to IDLE.
- read_data_req in any state other than HDR/PAY is ignored: no fifo_rdreq, send_data holds its last value.

frame_start handling:
- In IDLE: frame_cnt increments and pkt_seq = 0 immediately.
- In any other state: the event is latched as pending. On return to IDLE, frame_cnt increments and pkt_seq = 0; the reset takes priority over the send_end increment.
- A second frame_start while one is already pending is merged into it, so frame_cnt advances by 1 only.

Wrap-around:
- frame_cnt and pkt_seq wrap modulo 2^16.

Reset mid-packet:
- Asynchronous return to IDLE. The FIFO is not drained; the next packet starts from whatever the FIFO holds.

Test Plan:
- Defaults; fifo_usedw 320; read_data_req for 321 cycles → one send_en pulse and send_data_num = 1284. First word after the header read = {frame_cnt, pkt_seq}. Exactly 320 fifo_rdreq. fifo_q 0x11223344 appears as send_data 0x44332211.
- BYTE_SWAP=0, HDR_EN=0 → send_data_num = 1280 and send_data = fifo_q unchanged.
- fifo_usedw held at 17 for 4096 cycles → send_en on timeout; send_data_num = (17+1)×4 = 72; 17 FIFO reads.
- Three packets, then frame_start during the third packet → pkt_seq goes 0,1,2. The third header carries seq 2. After send_end: frame_cnt = 1, pkt_seq = 0.
- fifo_empty asserted mid-payload → no fifo_rdreq, send_data = 0, underrun = 1 and stays set. Total words requested still equals n + 1.
- rst_n low in the middle of PAY → all outputs 0 asynchronously. After release, IDLE and the next packet behave normally.
